// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer driving the datapath
// controls decoded from the current state, the instruction register and the stored flags.
module stump_control (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] ir_i,
    input  logic [3:0]  cc_i,
    output logic [1:0]  state_o,
    output logic        fetch_o,
    output logic        ir_en_o,
    output logic        addr_en_o,
    output logic [2:0]  alu_func_o,
    output logic        cc_en_o,
    output logic [2:0]  src_a_o,
    output logic [2:0]  src_b_o,
    output logic [2:0]  dest_o,
    output logic        reg_write_o,
    output logic        opb_sel_o,
    output logic [1:0]  ext_op_o,
    output logic [1:0]  shift_op_o,
    output logic        wb_sel_o,
    output logic        mem_ren_o,
    output logic        mem_wen_o,
    output logic        branch_taken_o
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [2:0] op_s;
    logic       type_s;
    logic       s_bit_s;
    logic [2:0] dst_s;
    logic [2:0] fld_a_s;
    logic [2:0] fld_b_s;
    logic [1:0] shift_s;
    logic [3:0] cond_s;
    logic       is_load_s;
    logic       cond_true_s;

    // Branch condition over the stored flags {N,Z,V,C}.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n;
        logic z;
        logic v;
        logic c;
        logic r;
        n = flags[3];
        z = flags[2];
        v = flags[1];
        c = flags[0];
        case (cond)
            4'h0:    r = 1'b1;
            4'h1:    r = 1'b0;
            4'h2:    r = !c && !z;
            4'h3:    r = c || z;
            4'h4:    r = !c;
            4'h5:    r = c;
            4'h6:    r = !z;
            4'h7:    r = z;
            4'h8:    r = !v;
            4'h9:    r = v;
            4'hA:    r = !n;
            4'hB:    r = n;
            4'hC:    r = (n == v);
            4'hD:    r = (n != v);
            4'hE:    r = !z && (n == v);
            4'hF:    r = z || (n != v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign op_s        = ir_i[15:13];
    assign type_s      = ir_i[12];
    assign s_bit_s     = ir_i[11];
    assign dst_s       = ir_i[10:8];
    assign fld_a_s     = ir_i[7:5];
    assign fld_b_s     = ir_i[4:2];
    assign shift_s     = ir_i[1:0];
    assign cond_s      = ir_i[11:8];
    assign is_load_s   = ir_i[11];
    assign cond_true_s = cond_eval(cond_s, cc_i);
    assign state_o     = state_q;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_d        = ST_FETCH;
        fetch_o        = 1'b0;
        ir_en_o        = 1'b0;
        addr_en_o      = 1'b0;
        alu_func_o     = 3'b000;
        cc_en_o        = 1'b0;
        src_a_o        = 3'd0;
        src_b_o        = 3'd0;
        dest_o         = 3'd0;
        reg_write_o    = 1'b0;
        opb_sel_o      = 1'b0;
        ext_op_o       = 2'b00;
        shift_op_o     = 2'b00;
        wb_sel_o       = 1'b0;
        mem_ren_o      = 1'b0;
        mem_wen_o      = 1'b0;
        branch_taken_o = 1'b0;
        case (state_q)
            ST_EXECUTE: begin
                if (op_s <= 3'b101) begin
                    state_d     = ST_FETCH;
                    alu_func_o  = op_s;
                    src_a_o     = fld_a_s;
                    dest_o      = dst_s;
                    reg_write_o = 1'b1;
                    cc_en_o     = s_bit_s;
                    if (type_s) begin
                        opb_sel_o  = 1'b1;
                        ext_op_o   = 2'b00;
                        shift_op_o = 2'b00;
                    end else begin
                        src_b_o    = fld_b_s;
                        shift_op_o = shift_s;
                        opb_sel_o  = 1'b0;
                    end
                end else if (op_s == 3'b110) begin
                    // Address = A + (B or imm5); the transfer itself happens in MEMORY.
                    state_d    = ST_MEMORY;
                    alu_func_o = 3'b000;
                    src_a_o    = fld_a_s;
                    addr_en_o  = 1'b1;
                    if (type_s) begin
                        opb_sel_o = 1'b1;
                        ext_op_o  = 2'b00;
                    end else begin
                        src_b_o   = fld_b_s;
                        opb_sel_o = 1'b0;
                    end
                end else begin
                    state_d = ST_FETCH;
                    if (type_s && cond_true_s) begin
                        branch_taken_o = 1'b1;
                        src_a_o        = 3'd7;
                        dest_o         = 3'd7;
                        reg_write_o    = 1'b1;
                        alu_func_o     = 3'b000;
                        opb_sel_o      = 1'b1;
                        ext_op_o       = 2'b01;
                    end else begin
                        branch_taken_o = 1'b0;
                    end
                end
            end
            ST_MEMORY: begin
                state_d = ST_FETCH;
                src_a_o = fld_a_s;
                src_b_o = fld_b_s;
                if (is_load_s) begin
                    mem_ren_o   = 1'b1;
                    wb_sel_o    = 1'b1;
                    dest_o      = dst_s;
                    reg_write_o = 1'b1;
                end else begin
                    // Store data is read through port A.
                    mem_wen_o = 1'b1;
                    src_a_o   = dst_s;
                end
            end
            default: begin
                // FETCH, and the unreachable encoding 11, fetch and bump the PC.
                state_d     = ST_EXECUTE;
                fetch_o     = 1'b1;
                mem_ren_o   = 1'b1;
                ir_en_o     = 1'b1;
                src_a_o     = 3'd7;
                dest_o      = 3'd7;
                reg_write_o = 1'b1;
                alu_func_o  = 3'b000;
                opb_sel_o   = 1'b1;
                ext_op_o    = 2'b10;
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control.sv
// Bench for stump_control: instruction-level model compared every cycle,
// plus hand-computed literal checks on the documented examples.
module tb_stump_control;

    typedef struct packed {
        logic [1:0] state;
        logic       fetch;
        logic       ir_en;
        logic       addr_en;
        logic [2:0] alu_func;
        logic       cc_en;
        logic [2:0] src_a;
        logic [2:0] src_b;
        logic [2:0] dest;
        logic       reg_write;
        logic       opb_sel;
        logic [1:0] ext_op;
        logic [1:0] shift_op;
        logic       wb_sel;
        logic       mem_ren;
        logic       mem_wen;
        logic       branch_taken;
    } outs_t;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  cc;
    outs_t       got;

    int n_chk  = 0;
    int n_pass = 0;
    int phase;

    stump_control dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ir_i           (ir),
        .cc_i           (cc),
        .state_o        (got.state),
        .fetch_o        (got.fetch),
        .ir_en_o        (got.ir_en),
        .addr_en_o      (got.addr_en),
        .alu_func_o     (got.alu_func),
        .cc_en_o        (got.cc_en),
        .src_a_o        (got.src_a),
        .src_b_o        (got.src_b),
        .dest_o         (got.dest),
        .reg_write_o    (got.reg_write),
        .opb_sel_o      (got.opb_sel),
        .ext_op_o       (got.ext_op),
        .shift_op_o     (got.shift_op),
        .wb_sel_o       (got.wb_sel),
        .mem_ren_o      (got.mem_ren),
        .mem_wen_o      (got.mem_wen),
        .branch_taken_o (got.branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Conditions come in complementary pairs: odd codes invert the even one.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, v, c, base;
        {n, z, v, c} = f;
        case (cond[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !c && !z;
            3'd2: base = !c;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ cond[0];
    endfunction

    // Expected controls for a given instruction phase (0 fetch, 1 execute, 2 memory).
    function automatic outs_t model(input int ph, input logic [15:0] i, input logic [3:0] f);
        outs_t o;
        o = '0;
        if (ph == 0) begin
            o.fetch = 1'b1; o.mem_ren = 1'b1; o.ir_en = 1'b1;
            o.src_a = 3'd7; o.dest = 3'd7; o.reg_write = 1'b1;
            o.opb_sel = 1'b1; o.ext_op = 2'b10;
        end else if (ph == 1) begin
            o.state = 2'b01;
            if (i[15:13] < 3'd6) begin
                o.alu_func = i[15:13]; o.src_a = i[7:5]; o.dest = i[10:8];
                o.reg_write = 1'b1; o.cc_en = i[11];
                if (i[12]) o.opb_sel = 1'b1;
                else begin o.src_b = i[4:2]; o.shift_op = i[1:0]; end
            end else if (i[15:13] == 3'd6) begin
                o.src_a = i[7:5]; o.addr_en = 1'b1;
                if (i[12]) o.opb_sel = 1'b1;
                else o.src_b = i[4:2];
            end else if (i[12] && cond_holds(i[11:8], f)) begin
                o.branch_taken = 1'b1; o.src_a = 3'd7; o.dest = 3'd7;
                o.reg_write = 1'b1; o.opb_sel = 1'b1; o.ext_op = 2'b01;
            end
        end else begin
            o.state = 2'b10;
            o.src_a = i[7:5]; o.src_b = i[4:2];
            if (i[11]) begin
                o.mem_ren = 1'b1; o.wb_sel = 1'b1; o.dest = i[10:8]; o.reg_write = 1'b1;
            end else begin
                o.mem_wen = 1'b1; o.src_a = i[10:8];
            end
        end
        return o;
    endfunction

    // Phase tracker: FETCH, EXECUTE, then MEMORY only for LD/ST.
    always @(posedge clk or posedge rst) begin
        if (rst) phase <= 0;
        else if (phase == 0) phase <= 1;
        else if (phase == 1 && ir[15:13] == 3'd6) phase <= 2;
        else phase <= 0;
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        outs_t exp_o;
        exp_o = model(phase, ir, cc);
        n_chk++;
        if (got === exp_o) n_pass++;
        else $display("FAIL model ph=%0d ir=%h cc=%b got=%h exp=%h", phase, ir, cc, got, exp_o);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] i, input logic [3:0] f);
        ir = i;
        cc = f;
    endtask

    logic [15:0] vec [10];

    initial begin
        vec = '{16'h0A54, 16'h1A43, 16'h2B6D, 16'h4C9E, 16'hA123, 16'h8FFF,
                16'hD940, 16'hD140, 16'hC25C, 16'hE0AB};
        rst = 1'b1;
        ir  = 16'h0000;
        cc  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {6'd0, got.state}, 8'h00);
        chk("rst_fetch", {5'd0, got.fetch, got.mem_ren, got.reg_write}, 8'h07);
        rst = 1'b0;

        // ADD R2,R2,R5 with S
        start(16'h0A54, 4'h0);
        #3 chk("fetch_srca", {5'd0, got.src_a}, 8'h07);
        chk("fetch_ext", {6'd0, got.ext_op}, 8'h02);
        step();
        chk("add0_state", {6'd0, got.state}, 8'h01);
        chk("add0_func", {5'd0, got.alu_func}, 8'h00);
        chk("add0_regs", {2'd0, got.src_a, got.src_b}, {2'd0, 3'd2, 3'd5});
        chk("add0_dest", {5'd0, got.dest}, 8'h02);
        chk("add0_ctl", {5'd0, got.reg_write, got.cc_en, got.opb_sel}, 8'h06);
        step();
        chk("add0_next", {6'd0, got.state}, 8'h00);

        // ADD R2,R2,#3 with S
        start(16'h1A43, 4'h0);
        step();
        chk("add1_ctl", {1'b0, got.opb_sel, got.ext_op, got.shift_op, got.cc_en, 1'b0}, 8'h42);
        step();

        // LD R1,[R2,#0]
        start(16'hD940, 4'h0);
        step();
        chk("ld_exec", {6'd0, got.addr_en, got.reg_write}, 8'h02);
        step();
        chk("ld_mem_state", {6'd0, got.state}, 8'h02);
        chk("ld_mem", {4'd0, got.mem_ren, got.wb_sel, got.reg_write, got.mem_wen}, 8'h0E);
        chk("ld_mem_dest", {5'd0, got.dest}, 8'h01);
        step();
        chk("ld_next", {6'd0, got.state}, 8'h00);

        // ST R1,[R2,#0]
        start(16'hD140, 4'h0);
        step();
        step();
        chk("st_mem", {5'd0, got.mem_wen, got.reg_write, got.mem_ren}, 8'h04);
        chk("st_srca", {5'd0, got.src_a}, 8'h01);
        step();

        // BEQ -2, taken then not taken
        start(16'hF7FE, 4'b0100);
        step();
        chk("beq_t", {2'd0, got.branch_taken, got.reg_write, got.dest, 1'b0}, {2'd0, 1'b1, 1'b1, 3'd7, 1'b0});
        chk("beq_t_ext", {6'd0, got.ext_op}, 8'h01);
        step();
        start(16'hF7FE, 4'b0000);
        step();
        chk("beq_nt", {6'd0, got.branch_taken, got.reg_write}, 8'h00);
        step();

        // Reset in the middle of EXECUTE acts without a clock edge
        start(16'hD940, 4'h0);
        step();
        #1 rst = 1'b1;
        #1 chk("async_rst", {5'd0, got.state, got.addr_en}, 8'h00);
        chk("async_rst_fetch", {5'd0, got.fetch, got.ir_en, got.reg_write}, 8'h07);
        start(16'h0A54, 4'h0);
        step();
        rst = 1'b0;
        #1 chk("rel_seq0", {6'd0, got.state}, 8'h00);
        step();
        chk("rel_seq1", {6'd0, got.state}, 8'h01);
        step();
        chk("rel_seq2", {6'd0, got.state}, 8'h00);

        // Mixed directed instructions; the per-cycle model checks every phase
        for (int k = 0; k < 10; k++) begin
            start(vec[k], 4'($urandom_range(15, 0)));
            step();
            if (phase == 2) step();
            step();
        end

        // Full condition x flag sweep
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                start({4'hF, 4'(c), 8'h05}, 4'(f));
                step();
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
